// File: rtl/tlul_cmd_pkg.sv
// Command, opcode and state types for the TL-UL command host.
package tlul_cmd_pkg;

   typedef enum logic [1:0] {
      OpWait  = 2'd0,
      OpRead  = 2'd1,
      OpWrite = 2'd2,
      OpNop   = 2'd3
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [31:0] addr;
      logic [31:0] data;
   } cmd_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StReq  = 2'd2,
      StRsp  = 2'd3
   } state_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL (32-bit data, 8-bit source) types shared by the command host and its bench.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   localparam logic [15:0] TL_A_USER_DEFAULT = 16'h0000;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [15:0] a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [15:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_cnt.sv
// Loadable counter with terminal flag: counts down to term (==) or up towards term (>=).
module tlul_cmd_cnt #(
   parameter int unsigned W       = 8,
   parameter bit          CountUp = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic [W-1:0] term_val_i,
   output logic         term_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = CountUp ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Up mode uses >= so a count that steps past term (handshake on the last REQ cycle) still expires.
   assign term_o = CountUp ? (cnt_q >= term_val_i) : (cnt_q == term_val_i);

endmodule

// File: rtl/tlul_cmd_host.sv
// Turns WAIT/READ/WRITE/NOP commands into single-outstanding TL-UL accesses with one response each.
//  state  | meaning
//  StIdle | ready for a command
//  StWait | burning WAIT cycles, counter down to zero
//  StReq  | a_valid high, waiting for a_ready
//  StRsp  | d_ready high, waiting for d_valid
module tlul_cmd_host
   import tlul_pkg::*;
   import tlul_cmd_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned WaitW         = 16,
   parameter int unsigned SourceId      = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  cmd_t        cmd_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output tl_h2d_t     tl_o,
   input  tl_d2h_t     tl_i,
   output logic        busy_o,
   output logic        timeout_o,
   output logic        stray_o
);

   localparam int unsigned TW    = $clog2(TimeoutCycles) + 1;
   localparam logic [7:0]  SrcId = 8'(SourceId);

   state_e      state_d, state_q;
   tl_a_op_e    a_opcode_d, a_opcode_q;
   logic [31:0] a_address_d, a_address_q;
   logic [31:0] a_data_d, a_data_q;
   logic        rsp_valid_d, rsp_valid_q;
   logic [31:0] rsp_data_d, rsp_data_q;
   logic        rsp_err_d, rsp_err_q;
   logic        timeout_d, timeout_q;
   logic        stray_d, stray_q;
   logic        wait_load, wait_done, tmo_load, tmo_hit, tmo_abort;
   logic        unused_tl;

   always_comb begin
      state_d     = state_q;
      a_opcode_d  = a_opcode_q;
      a_address_d = a_address_q;
      a_data_d    = a_data_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      timeout_d   = timeout_q;
      stray_d     = stray_q | (tl_i.d_valid & (state_q != StRsp));
      wait_load   = 1'b0;
      tmo_load    = 1'b0;
      tmo_abort   = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               case (cmd_i.op)
                  OpWait: begin
                     state_d   = StWait;
                     wait_load = 1'b1;
                  end
                  OpRead: begin
                     state_d     = StReq;
                     a_opcode_d  = Get;
                     a_address_d = cmd_i.addr;
                     a_data_d    = '0;
                     tmo_load    = 1'b1;
                  end
                  OpWrite: begin
                     state_d     = StReq;
                     a_opcode_d  = PutFullData;
                     a_address_d = cmd_i.addr;
                     a_data_d    = cmd_i.data;
                     tmo_load    = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         StWait: begin
            if (wait_done) state_d = StIdle;
         end
         StReq: begin
            if (tl_i.a_ready) state_d = StRsp;
            else              tmo_abort = tmo_hit;
         end
         StRsp: begin
            if (tl_i.d_valid) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b1;
               rsp_data_d  = (a_opcode_q == Get) ? tl_i.d_data : '0;
               rsp_err_d   = tl_i.d_error | (tl_i.d_source != SrcId);
            end else begin
               tmo_abort = tmo_hit;
            end
         end
         default: state_d = StIdle;
      endcase

      if (tmo_abort) begin
         state_d     = StIdle;
         rsp_valid_d = 1'b1;
         rsp_data_d  = '0;
         rsp_err_d   = 1'b1;
         timeout_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         a_opcode_q  <= PutFullData;
         a_address_q <= '0;
         a_data_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
         stray_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_opcode_q  <= a_opcode_d;
         a_address_q <= a_address_d;
         a_data_q    <= a_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         timeout_q   <= timeout_d;
         stray_q     <= stray_d;
      end
   end

   tlul_cmd_cnt #(.W(WaitW), .CountUp(1'b0)) u_wait_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (wait_load),
      .load_val_i (cmd_i.data[WaitW-1:0]),
      .en_i       (state_q == StWait),
      .term_val_i ('0),
      .term_o     (wait_done)
   );

   tlul_cmd_cnt #(.W(TW), .CountUp(1'b1)) u_tmo_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmo_load),
      .load_val_i ('0),
      .en_i       ((state_q == StReq) || (state_q == StRsp)),
      .term_val_i (TW'(TimeoutCycles - 1)),
      .term_o     (tmo_hit)
   );

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = (state_q == StReq);
      tl_o.a_opcode  = a_opcode_q;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = SrcId;
      tl_o.a_address = a_address_q;
      tl_o.a_mask    = 4'hF;
      tl_o.a_data    = a_data_q;
      tl_o.a_user    = TL_A_USER_DEFAULT;
      tl_o.d_ready   = (state_q == StRsp);
   end

   assign cmd_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign timeout_o   = timeout_q;
   assign stray_o     = stray_q;

   assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_cmd_host.sv
// Randomized bench for tlul_cmd_host: a cycle-scheduled device model plus transaction-level expectations.
module tb_tlul_cmd_host;
   import tlul_pkg::*;
   import tlul_cmd_pkg::*;

   localparam int TC = 16;
   localparam int WW = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   cmd_t        cmd_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic        busy_o, timeout_o, stray_o;

   int n_chk = 0;
   int n_err = 0;
   bit m_timeout = 1'b0;
   bit m_stray = 1'b0;

   always #5 clk_i = ~clk_i;

   tlul_cmd_host #(.TimeoutCycles(TC), .WaitW(WW), .SourceId(0)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_i       (cmd_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .tl_o        (tl_o),
      .tl_i        (tl_i),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .stray_o     (stray_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag);
      check_eq({tag, "_timeout"}, 32'(timeout_o), 32'(m_timeout));
      check_eq({tag, "_stray"}, 32'(stray_o), 32'(m_stray));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_a_valid"}, 32'(tl_o.a_valid), 32'd0);
      check_eq({tag, "_d_ready"}, 32'(tl_o.d_ready), 32'd0);
      check_eq({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      check_eq({tag, "_rsp_data"}, rsp_data_o, 32'd0);
      check_eq({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
      check_eq({tag, "_stray"}, 32'(stray_o), 32'd0);
   endtask

   // Called at a negedge with the host idle; returns at a negedge with the host idle.
   // Device raises a_ready ar_dly cycles into the request and d_valid dv_dly cycles after the handshake.
   task automatic run_bus(input bit is_rd, input logic [31:0] addr, input logic [31:0] data,
                          input int ar_dly, input int dv_dly, input bit derr,
                          input logic [7:0] dsrc, input logic [31:0] ddata);
      int resp_idx, e_idx, hs;
      bit tmo, av_exp;
      logic [31:0] exp_data;
      bit exp_err;
      resp_idx = ar_dly + dv_dly;
      tmo      = (resp_idx > TC - 1);
      e_idx    = tmo ? TC : resp_idx + 1;
      exp_err  = tmo | derr | (dsrc != 8'd0);
      exp_data = tmo ? 32'd0 : (is_rd ? ddata : 32'd0);
      hs = 0;

      check_eq("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b1;
      cmd_i.op    = is_rd ? OpRead : OpWrite;
      cmd_i.addr  = addr;
      cmd_i.data  = data;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      cmd_i.addr  = $urandom();
      cmd_i.data  = $urandom();

      for (int idx = 0; idx <= e_idx; idx++) begin
         av_exp = (idx <= ar_dly) && (idx < e_idx);
         check_eq("a_valid", 32'(tl_o.a_valid), 32'(av_exp));
         check_eq("d_ready", 32'(tl_o.d_ready), 32'((idx > ar_dly) && (idx < e_idx)));
         check_eq("rsp_valid", 32'(rsp_valid_o), 32'(idx == e_idx));
         check_eq("busy", 32'(busy_o), 32'(idx < e_idx));
         if (av_exp) begin
            check_eq("a_opcode", 32'(tl_o.a_opcode), is_rd ? 32'd4 : 32'd0);
            check_eq("a_address", tl_o.a_address, addr);
            check_eq("a_data", tl_o.a_data, is_rd ? 32'd0 : data);
            if (idx == 0) begin
               check_eq("a_mask", 32'(tl_o.a_mask), 32'hF);
               check_eq("a_size", 32'(tl_o.a_size), 32'd2);
               check_eq("a_source", 32'(tl_o.a_source), 32'd0);
               check_eq("a_param", 32'(tl_o.a_param), 32'd0);
            end
         end
         if (idx < e_idx) begin
            tl_i.a_ready  = (idx == ar_dly);
            tl_i.d_valid  = !tmo && (idx == resp_idx);
            tl_i.d_opcode = is_rd ? AccessAckData : AccessAck;
            tl_i.d_data   = ddata;
            tl_i.d_error  = derr;
            tl_i.d_source = dsrc;
            hs += int'(tl_o.a_valid & tl_i.a_ready);
            @(negedge clk_i);
         end
         tl_i.a_ready = 1'b0;
         tl_i.d_valid = 1'b0;
      end

      if (tmo) m_timeout = 1'b1;
      check_eq("rsp_data", rsp_data_o, exp_data);
      check_eq("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      check_eq("cmd_ready_after", 32'(cmd_ready_o), 32'd1);
      check_eq("handshakes", 32'(hs), (ar_dly < e_idx) ? 32'd1 : 32'd0);
      check_flags("bus");
      @(negedge clk_i);
      check_eq("rsp_pulse_1cyc", 32'(rsp_valid_o), 32'd0);
   endtask

   task automatic run_wait(input int n);
      int cnt;
      cnt = 0;
      cmd_valid_i = 1'b1;
      cmd_i.op    = OpWait;
      cmd_i.addr  = $urandom();
      cmd_i.data  = {16'($urandom()), 16'(n)};
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < n + 10; i++) begin
         if (!busy_o) break;
         check_eq("wait_a_valid", 32'(tl_o.a_valid), 32'd0);
         check_eq("wait_rsp", 32'(rsp_valid_o), 32'd0);
         check_eq("wait_cmd_ready", 32'(cmd_ready_o), 32'd0);
         cnt++;
         @(negedge clk_i);
      end
      check_eq("wait_cycles", 32'(cnt), 32'(n + 1));
      check_eq("wait_end_rsp", 32'(rsp_valid_o), 32'd0);
   endtask

   task automatic run_nop();
      cmd_valid_i = 1'b1;
      cmd_i.op    = OpNop;
      cmd_i.addr  = $urandom();
      cmd_i.data  = $urandom();
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      check_eq("nop_busy", 32'(busy_o), 32'd0);
      check_eq("nop_rsp", 32'(rsp_valid_o), 32'd0);
      check_eq("nop_a_valid", 32'(tl_o.a_valid), 32'd0);
   endtask

   task automatic run_stray();
      check_eq("stray_d_ready", 32'(tl_o.d_ready), 32'd0);
      tl_i.d_valid  = 1'b1;
      tl_i.d_source = 8'($urandom_range(0, 1));
      tl_i.d_data   = $urandom();
      @(negedge clk_i);
      tl_i.d_valid = 1'b0;
      m_stray = 1'b1;
      check_eq("stray_rsp", 32'(rsp_valid_o), 32'd0);
      check_eq("stray_busy", 32'(busy_o), 32'd0);
      check_flags("stray");
   endtask

   initial begin
      int op, ar, dv;
      cmd_valid_i = 1'b0;
      cmd_i = '0;
      tl_i = '0;
      #2;
      check_reset_outputs("in_reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_reset_outputs("after_reset");

      run_bus(1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1, 1'b0, 8'd0, 32'h0);
      run_bus(1'b1, 32'h20, 32'h0, 0, 5, 1'b0, 8'd0, 32'h1234_5678);
      run_bus(1'b1, 32'h44, 32'h0, 3, 1, 1'b0, 8'd0, 32'hCAFE_F00D);
      run_wait(0);
      run_wait(7);
      run_nop();
      run_bus(1'b1, 32'h30, 32'h0, 100, 1, 1'b0, 8'd0, 32'h5555_AAAA);
      run_bus(1'b0, 32'h34, 32'h0BAD_F00D, 0, 100, 1'b0, 8'd0, 32'h0);
      run_bus(1'b1, 32'h38, 32'h0, 0, 2, 1'b0, 8'd0, 32'h0F0F_0F0F);
      run_bus(1'b1, 32'h3C, 32'h0, 1, 2, 1'b1, 8'd0, 32'h1111_2222);
      run_bus(1'b0, 32'h40, 32'h1357_9BDF, 2, 1, 1'b0, 8'd1, 32'h0);
      run_stray();

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 1) begin
            run_wait(int'($urandom_range(0, 12)));
         end else if (op == 2) begin
            run_nop();
         end else if (op == 3) begin
            run_stray();
         end else begin
            ar = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 4));
            dv = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 6));
            run_bus(op[0], $urandom() & 32'hFFFF_FFFC, $urandom(), ar, dv,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0,
                    $urandom());
         end
      end

      // Reset while a read sits in RSP must clear everything in the same cycle.
      cmd_valid_i = 1'b1;
      cmd_i.op    = OpRead;
      cmd_i.addr  = 32'h80;
      cmd_i.data  = 32'h0;
      @(negedge clk_i);
      cmd_valid_i  = 1'b0;
      tl_i.a_ready = 1'b1;
      @(negedge clk_i);
      tl_i.a_ready = 1'b0;
      check_eq("pre_rst_d_ready", 32'(tl_o.d_ready), 32'd1);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("rst_in_rsp");
      m_timeout = 1'b0;
      m_stray = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_bus(1'b1, 32'h84, 32'h0, 1, 1, 1'b0, 8'd0, 32'h7777_8888);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
